// File: rtl/ccff_chain_loader_if.sv
// ============================================================================
// Module  : ccff_chain_loader_if
// Purpose : Host-to-loader bitstream word handshake (valid/ready plus data).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
) ();
    logic              cfg_valid;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready
    );
endinterface

`default_nettype wire

// File: rtl/ccff_chain_loader.sv
// ============================================================================
// Module  : ccff_chain_loader
// Purpose : Serializes host words onto ccff_head for exactly CHAIN_LEN bits;
//           optional ccff_tail readback enabled by macro CCFF_READBACK_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic               prog_clk,
    input  logic               pReset_n,
    input  logic               start,
    input  logic               abort,
    ccff_chain_loader_if.slave cfg,
    output logic               ccff_head,
    output logic               config_enable,
    input  logic               ccff_tail,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               rb_valid,
    output logic [WORD_W-1:0]  rb_data
);
    localparam int BS_W  = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t            state_q;
    logic [WORD_W-1:0] sr_q;
    logic [BS_W-1:0]   bits_sent_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  last_q;
    logic              cfg_ready_q;
    logic              ccff_head_q;
    logic              config_enable_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [31:0]       remain_d;
    logic [IDX_W-1:0]  last_d;

    // Index of the last bit to shift from the word about to be accepted.
    always_comb begin
        remain_d = 32'(CHAIN_LEN) - 32'(bits_sent_q);
        if (remain_d >= 32'(WORD_W)) begin
            last_d = IDX_W'(WORD_W - 1);
        end else begin
            last_d = IDX_W'(remain_d - 32'd1);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            state_q         <= S_IDLE;
            sr_q            <= '0;
            bits_sent_q     <= '0;
            idx_q           <= '0;
            last_q          <= '0;
            cfg_ready_q     <= 1'b0;
            ccff_head_q     <= 1'b0;
            config_enable_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_FETCH;
                        busy_q      <= 1'b1;
                        cfg_ready_q <= 1'b1;
                        err_q       <= 1'b0;
                        bits_sent_q <= '0;
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b0;
                        err_q       <= 1'b1;
                    end else if (cfg.cfg_valid && cfg_ready_q) begin
                        // First bit goes out immediately; the rest wait in sr_q.
                        state_q         <= S_SHIFT;
                        cfg_ready_q     <= 1'b0;
                        sr_q            <= cfg.cfg_data >> 1;
                        ccff_head_q     <= cfg.cfg_data[0];
                        config_enable_q <= 1'b1;
                        bits_sent_q     <= bits_sent_q + BS_W'(1);
                        idx_q           <= '0;
                        last_q          <= last_d;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        state_q         <= S_IDLE;
                        busy_q          <= 1'b0;
                        config_enable_q <= 1'b0;
                        ccff_head_q     <= 1'b0;
                        err_q           <= 1'b1;
                    end else if (idx_q != last_q) begin
                        ccff_head_q <= sr_q[0];
                        sr_q        <= sr_q >> 1;
                        idx_q       <= idx_q + IDX_W'(1);
                        bits_sent_q <= bits_sent_q + BS_W'(1);
                    end else begin
                        config_enable_q <= 1'b0;
                        ccff_head_q     <= 1'b0;
                        if (bits_sent_q == BS_W'(CHAIN_LEN)) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= S_FETCH;
                            cfg_ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg.cfg_ready  = cfg_ready_q;
    assign ccff_head      = ccff_head_q;
    assign config_enable  = config_enable_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_sh_q;
    logic [WORD_W-1:0] rb_sh_d;
    logic [WORD_W-1:0] rb_data_q;
    logic              rb_valid_q;

    // Readback groups line up with host words, so the word bit index doubles as the slot.
    always_comb begin
        rb_sh_d        = rb_sh_q;
        rb_sh_d[idx_q] = ccff_tail;
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            rb_sh_q    <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;
            if (state_q == S_SHIFT) begin
                if (abort) begin
                    rb_sh_q <= '0;
                end else if (idx_q == last_q) begin
                    rb_data_q  <= rb_sh_d;
                    rb_valid_q <= 1'b1;
                    rb_sh_q    <= '0;
                end else begin
                    rb_sh_q <= rb_sh_d;
                end
            end
        end
    end

    assign rb_valid = rb_valid_q;
    assign rb_data  = rb_data_q;
`else
    logic unused_tail_w;
    assign unused_tail_w = ccff_tail;
    assign rb_valid      = 1'b0;
    assign rb_data       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
// ============================================================================
// Module  : tb_ccff_chain_loader
// Purpose : Self-checking bench: randomized loads against a bit-stream model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccff_chain_loader;
    localparam int CL = 20;
    localparam int WW = 8;
    localparam int NW = (CL + WW - 1) / WW;

    logic          prog_clk = 1'b0;
    logic          pReset_n = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic          ccff_head, config_enable, busy, done, err, rb_valid, ccff_tail;
    logic [WW-1:0] rb_data;

    ccff_chain_loader_if #(.WORD_W(WW)) cfg ();

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk      (prog_clk),
        .pReset_n      (pReset_n),
        .start         (start),
        .abort         (abort),
        .cfg           (cfg),
        .ccff_head     (ccff_head),
        .config_enable (config_enable),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .rb_valid      (rb_valid),
        .rb_data       (rb_data)
    );

    always #5 prog_clk = ~prog_clk;

    // Downstream chain model, preloaded with all ones.
    logic [CL-1:0] chain_m = '1;
    always @(posedge prog_clk) if (config_enable) chain_m <= {chain_m[CL-2:0], ccff_head};
    assign ccff_tail = chain_m[CL-1];

    int checks = 0;
    int errors = 0;

    bit            stream[$];
    logic [WW-1:0] rb_q[$];
    int            done_cnt, busy_cyc, head_bad, rb_done_last;
    int            host_words[$];
    int            load_words[$];
    int            fetch_idx, stall_at, stall_left, stall_bad;
    bit            prev_stream[$];
    bit            prev_known;

    initial begin : monitor
        forever begin
            @(negedge prog_clk);
            if (config_enable) stream.push_back(ccff_head);
            if (!config_enable && ccff_head) head_bad++;
            if (done) done_cnt++;
            if (busy) busy_cyc++;
            if (rb_valid) begin
                rb_q.push_back(rb_data);
                rb_done_last = int'(done);
            end
        end
    end

    initial begin : host
        cfg.cfg_valid = 1'b0;
        cfg.cfg_data  = '0;
        forever begin
            @(negedge prog_clk);
            cfg.cfg_valid = 1'b0;
            if (cfg.cfg_ready && host_words.size() > 0) begin
                if (fetch_idx == stall_at && stall_left > 0) begin
                    stall_left--;
                    if (config_enable) stall_bad++;
                end else begin
                    cfg.cfg_valid = 1'b1;
                    cfg.cfg_data  = WW'(host_words.pop_front());
                    fetch_idx++;
                end
            end
        end
    end

    function automatic bit exp_bit(input int i);
        int w;
        w = load_words[i / WW];
        return w[i % WW];
    endfunction

    // mode: 0 normal, 1 abort after abort_at shifts, 2 reset after rst_at cycles
    task automatic run_load(input int st_at, input int st_len, input int mid_start,
                            input bit with_abort, input int mode, input int ev_at);
        bit            fin;
        int            exp_busy;
        logic [CL-1:0] exp_v, got_v;
        logic [WW-1:0] exp_rb;
        stream.delete(); rb_q.delete();
        done_cnt = 0; busy_cyc = 0; head_bad = 0; stall_bad = 0; rb_done_last = 0;
        fetch_idx = 0; stall_at = st_at; stall_left = st_len;
        host_words = load_words;
        @(negedge prog_clk); #1;
        start = 1'b1; abort = with_abort;
        @(negedge prog_clk); #1;
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b1 || cfg.cfg_ready !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL start_response: busy=%b ready=%b err=%b, required 1 1 0",
                     busy, cfg.cfg_ready, err);
        end
        fin = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (mid_start > 0 && c == mid_start) start = 1'b1;
            if (mode == 2 && c == ev_at) pReset_n = 1'b0;
            if (mode == 1 && stream.size() == ev_at) abort = 1'b1;
            @(negedge prog_clk); #1;
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                fin   = 1'b1;
                checks++;
                if (config_enable !== 1'b0 || busy !== 1'b0 || err !== 1'b1 || cfg.cfg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_response: ce=%b busy=%b err=%b ready=%b, required 0 0 1 0",
                             config_enable, busy, err, cfg.cfg_ready);
                end
                repeat (5) @(negedge prog_clk);
                #1;
                checks++;
                if (done_cnt !== 0 || stream.size() !== ev_at) begin
                    errors++;
                    $display("FAIL abort_quiet: done_pulses=%0d shifts=%0d, required 0 %0d",
                             done_cnt, stream.size(), ev_at);
                end
`ifdef CCFF_READBACK_EN
                checks++;
                if (rb_q.size() !== ev_at / WW) begin
                    errors++;
                    $display("FAIL abort_readback: words=%0d, required %0d", rb_q.size(), ev_at / WW);
                end
`endif
                host_words.delete();
                prev_known = 1'b0;
            end else if (!pReset_n) begin
                pReset_n = 1'b1;
                fin      = 1'b1;
                checks++;
                if ({ccff_head, config_enable, busy, done, err, cfg.cfg_ready, rb_valid} !== 7'b0
                    || rb_data !== '0) begin
                    errors++;
                    $display("FAIL reset_midload: head=%b ce=%b busy=%b done=%b err=%b ready=%b rbv=%b rbd=%h, required all 0",
                             ccff_head, config_enable, busy, done, err, cfg.cfg_ready, rb_valid, rb_data);
                end
                host_words.delete();
                prev_known = 1'b0;
                repeat (3) @(negedge prog_clk);
            end else if (done_cnt > 0) begin
                fin = 1'b1;
            end
        end
        if (!fin) begin
            errors++;
            $display("FAIL load_timeout: done never pulsed within 400 cycles");
        end
        if (mode == 0 && fin) begin
            repeat (3) @(negedge prog_clk);
            #1;
            exp_busy = NW + CL + st_len;
            for (int i = 0; i < CL; i++) begin
                exp_v[i] = exp_bit(i);
                got_v[i] = (i < stream.size()) ? stream[i] : 1'bx;
            end
            checks++;
            if (stream.size() !== CL || got_v !== exp_v) begin
                errors++;
                $display("FAIL head_stream: shifts=%0d bits=%b, required %0d bits=%b",
                         stream.size(), got_v, CL, exp_v);
            end
            checks++;
            if (done_cnt !== 1 || busy_cyc !== exp_busy) begin
                errors++;
                $display("FAIL load_timing: done_pulses=%0d busy_cycles=%0d, required 1 %0d",
                         done_cnt, busy_cyc, exp_busy);
            end
            checks++;
            if (head_bad !== 0 || stall_bad !== 0 || stall_left !== 0 || err !== 1'b0) begin
                errors++;
                $display("FAIL qualification: head_unqualified=%0d stall_shift=%0d stall_left=%0d err=%b, required 0 0 0 0",
                         head_bad, stall_bad, stall_left, err);
            end
`ifdef CCFF_READBACK_EN
            if (prev_known) begin
                checks++;
                if (rb_q.size() !== NW || rb_done_last !== 1) begin
                    errors++;
                    $display("FAIL readback_count: words=%0d last_with_done=%0d, required %0d 1",
                             rb_q.size(), rb_done_last, NW);
                end
                for (int g = 0; g < NW && g < rb_q.size(); g++) begin
                    exp_rb = '0;
                    for (int b = 0; b < WW; b++)
                        if (g * WW + b < CL) exp_rb[b] = prev_stream[g * WW + b];
                    checks++;
                    if (rb_q[g] !== exp_rb) begin
                        errors++;
                        $display("FAIL readback_word%0d: got %h, required %h", g, rb_q[g], exp_rb);
                    end
                end
            end
`else
            checks++;
            if (rb_q.size() !== 0 || rb_data !== '0) begin
                errors++;
                $display("FAIL readback_disabled: words=%0d rb_data=%h, required 0 0", rb_q.size(), rb_data);
            end
`endif
            prev_stream.delete();
            for (int i = 0; i < CL; i++) prev_stream.push_back(exp_bit(i));
            prev_known = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge prog_clk);
        #1;
        checks++;
        if ({ccff_head, config_enable, busy, done, err, cfg.cfg_ready, rb_valid} !== 7'b0 || rb_data !== '0) begin
            errors++;
            $display("FAIL reset_state: head=%b ce=%b busy=%b done=%b err=%b ready=%b rbv=%b rbd=%h, required all 0",
                     ccff_head, config_enable, busy, done, err, cfg.cfg_ready, rb_valid, rb_data);
        end
        pReset_n = 1'b1;
        for (int i = 0; i < CL; i++) prev_stream.push_back(1'b1);
        prev_known = 1'b1;
    endtask

    task automatic test_readback_zeros();
        load_words = '{8'h00, 8'h00, 8'h00};
        run_load(-1, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_basic();
        load_words = '{8'hA5, 8'h3C, 8'h0F};
        run_load(-1, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_partial();
        load_words = '{8'hA5, 8'h3C, 8'hFF};
        run_load(-1, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_stall();
        load_words = '{8'hA5, 8'h3C, 8'h0F};
        run_load(1, 5, 0, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            load_words = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 255))};
            run_load(int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 0, 1'b0, 0, 0);
        end
    endtask

    task automatic test_start_during_shift();
        load_words = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 8'h5A};
        run_load(-1, 0, 4, 1'b0, 0, 0);
    endtask

    task automatic test_abort();
        load_words = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 8'hC3};
        run_load(-1, 0, 0, 1'b0, 1, 10);
    endtask

    task automatic test_start_with_abort();
        load_words = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255))};
        run_load(-1, 0, 0, 1'b1, 0, 0);
    endtask

    task automatic test_reset_midload();
        load_words = '{8'hFF, 8'hFF, 8'hFF};
        run_load(-1, 0, 0, 1'b0, 2, 6);
    endtask

    initial begin
        test_reset();
        test_readback_zeros();
        test_basic();
        test_partial();
        test_stall();
        test_random();
        test_start_during_shift();
        test_abort();
        test_start_with_abort();
        test_reset_midload();
        test_basic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain loader that sits directly upstream of the `ccff_head` input of a tile's configuration chain, such as the fle/fabric chain of frac_logic, ff_0, ff_1 and the output mux memory. It accepts bitstream words from a host over a valid/ready handshake and serializes exactly `CHAIN_LEN` bits onto `ccff_head`. It qualifies every shift with `config_enable` and reports completion, abort and, optionally, the previous chain contents read back from `ccff_tail`.

## Interface
- `CHAIN_LEN`, default 64: number of configuration flip-flops in the downstream chain; legal range is ≥1.
- `WORD_W`, default 8: host word width; legal range is 1–32.
- `prog_clk` input 1: programming clock; shared with the chain it drives.
- `pReset_n` input 1: reset, **synchronous, active-low**; one clock (`prog_clk`). Already decided.
- `start` input 1: single-cycle request to begin a load; honoured only in IDLE.
- `abort` input 1: terminates a load in progress.
- `cfg_valid` input 1: host word valid.
- `cfg_data` input `WORD_W`: host word; bit 0 is shifted first.
- `cfg_ready` output 1: loader can accept a word.
- `ccff_head` output 1: serial bit into the chain.
- `config_enable` output 1: the chain captures `ccff_head` on this rising edge.
- `ccff_tail` input 1: serial bit out of the chain.
- `busy` output 1: load in progress.
- `done` output 1: one-cycle pulse when a load completes.
- `err` output 1: sticky abort flag.
- `rb_valid` output 1: one-cycle pulse, readback word ready.
- `rb_data` output `WORD_W`: readback word; bit 0 is the first bit captured.

## Operation
- The loader has three states: IDLE, FETCH and SHIFT.
- **IDLE**
  - `busy` = 0.
  - `start` = 1 moves to FETCH, clears `err` and clears the bit counter `bits_sent`.
- **FETCH**
  - `cfg_ready` = 1.
  - On `cfg_valid & cfg_ready`, capture `cfg_data` into the shift register and go to SHIFT.
  - The shift count for the word is `n = min(WORD_W, CHAIN_LEN - bits_sent)`.
  - The host may hold `cfg_valid` low indefinitely; the loader waits with `config_enable` = 0.
- **SHIFT**
  - Each cycle drives `ccff_head` = shift register bit 0 and `config_enable` = 1.
  - The shift register moves right by one, and `bits_sent` increments.
  - After n cycles:
    - If `bits_sent == CHAIN_LEN`, go to IDLE and pulse `done`.
    - Otherwise, go to FETCH.
  - If `CHAIN_LEN` is not a multiple of `WORD_W`, the final word uses only its low `CHAIN_LEN mod WORD_W` bits. Its upper bits are discarded and never reach `ccff_head`.
- **Counters**
  - `bits_sent` is `$clog2(CHAIN_LEN+1)` bits wide and never exceeds `CHAIN_LEN`.
  - The total count of `config_enable`-high cycles per completed load is exactly `CHAIN_LEN`.
- **abort** (any non-IDLE state)
  - Next state is IDLE; `config_enable` and `cfg_ready` drop at the next edge.
  - `err` is set to 1; `done` does not pulse.
  - A word offered in the same cycle is not accepted, because `abort` takes priority over the handshake.
- **Simultaneous events**
  - `start` outside IDLE is ignored.
  - `start` and `abort` together in IDLE: `start` wins, so no error is raised.
- **Reset mid-load:** the loader returns to IDLE with all outputs at their reset values and `err` = 0. Chain contents are undefined and the host must reload.
- **Output qualification:** `ccff_head` is 0 whenever `config_enable` = 0.

## Timing
- All outputs are registered.
- Reset values: `cfg_ready`, `ccff_head`, `config_enable`, `busy`, `done`, `err`, `rb_valid` are all 0, and `rb_data` = 0.
- `start` sampled at edge k gives `busy` = 1 and `cfg_ready` = 1 from edge k+1.
- A word accepted at edge a puts its first bit on `ccff_head` with `config_enable` = 1 during cycle a+1, captured by the chain at edge a+2.
- Cost per word is one FETCH cycle plus n SHIFT cycles. A load with zero host stall takes `ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN` cycles.
- `done` pulses in the cycle after the last `config_enable`-high cycle. `busy` falls in the same cycle.

## Configuration
- Macro: `CCFF_READBACK_EN`.
- **Defined:**
  - On every `config_enable`-high edge, the bit on `ccff_tail` (the old chain content, oldest first) is shifted into a readback register.
  - `rb_valid` pulses one cycle after each group of `WORD_W` captured bits, and after the final partial group at load end, concurrent with `done`.
  - In a partial group, the unused upper bits of `rb_data` are 0.
  - `rb_data` holds its value until the next `rb_valid`.
  - An aborted load emits no partial readback word.
- **Not defined:** `rb_valid` and `rb_data` are tied to 0, `ccff_tail` is ignored, and no readback registers exist.

## Test plan
- **Basic load:** reset, then `CHAIN_LEN`=20, `WORD_W`=8, words 0xA5, 0x3C, 0x0F with no stall.
  - `ccff_head` sequence is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1.
  - `config_enable` is high for exactly 20 cycles and `done` pulses once.
  - The load takes 23 cycles from the first `cfg_ready`.
- **Partial final word:** same setup, with the last word 0xFF instead of 0x0F. Only 4 ones are shifted and the total shift count is still 20.
- **Host stall:** hold `cfg_valid` low for 5 cycles in the second FETCH. `config_enable` = 0 throughout the stall, `cfg_ready` stays 1, and the output bit stream is unchanged.
- **Abort:** assert `abort` after 10 shifts.
  - Next cycle: `config_enable` = 0, `busy` = 0, `err` = 1, no `done`.
  - A following `start` clears `err`.
- **Reset and start edge cases:**
  - `pReset_n` low mid-SHIFT gives all outputs 0 on the next edge.
  - `start` during SHIFT is ignored.
  - `start` together with `abort` in IDLE begins a load with `err` = 0.
- **Readback (`CCFF_READBACK_EN`):** preload a chain model with 20 ones, then load 0x00 ×3.
  - `rb_data` = 0xFF, 0xFF, 0x0F, with `rb_valid` pulsing 3 times.
  - The last pulse coincides with `done`.
